// File: rtl/rail_sample_scheduler_if.sv
// Bus between the frame producer/consumer side and the rail sample scheduler.
interface rail_sample_scheduler_if #(
  parameter int unsigned NUMADCS = 5,
  parameter int unsigned DATA_W  = 16
);
  localparam int unsigned CHAN_W = (NUMADCS > 1) ? $clog2(NUMADCS) : 1;

  logic                data_ready;
  logic [DATA_W-1:0]   in_data [NUMADCS];
  logic [NUMADCS-1:0]  chan_en;
  logic [DATA_W-1:0]   limit;
  logic                fault_clr;
  logic                out_ready;
  logic                out_valid;
  logic [CHAN_W-1:0]   out_chan;
  logic [DATA_W-1:0]   out_data;
  logic [NUMADCS-1:0]  fault;
  logic                overrun;
  logic [7:0]          frame_cnt;
  logic                busy;

  modport master (
    output data_ready, in_data, chan_en, limit, fault_clr, out_ready,
    input  out_valid, out_chan, out_data, fault, overrun, frame_cnt, busy
  );

  modport slave (
    input  data_ready, in_data, chan_en, limit, fault_clr, out_ready,
    output out_valid, out_chan, out_data, fault, overrun, frame_cnt, busy
  );
endinterface

// File: rtl/rail_sample_scheduler.sv
// Rail sample scheduler: snapshots a decimated ADC frame and streams the
// enabled channels out in ascending order over a valid/ready handshake,
// flagging over-limit samples and frames dropped while busy.
module rail_sample_scheduler #(
  parameter int unsigned NUMADCS = 5,
  parameter int unsigned DATA_W  = 16
) (
  input logic                    sclk,
  input logic                    rst,
  rail_sample_scheduler_if.slave bus
);
  localparam int unsigned CHAN_W = (NUMADCS > 1) ? $clog2(NUMADCS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [NUMADCS-1:0] pending_q, pending_d;
  logic [DATA_W-1:0]  shadow_q [NUMADCS];
  logic [DATA_W-1:0]  shadow_d [NUMADCS];
  logic [CHAN_W-1:0]  out_chan_q, out_chan_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [NUMADCS-1:0] fault_q, fault_d;
  logic               overrun_q, overrun_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [NUMADCS-1:0] remain;
  logic [CHAN_W-1:0]  sel;

  // Index of the lowest set bit; zero for an empty mask.
  function automatic logic [CHAN_W-1:0] lowest_set(input logic [NUMADCS-1:0] m);
    logic [CHAN_W-1:0] idx;
    idx = '0;
    for (int i = int'(NUMADCS) - 1; i >= 0; i--) begin
      if (m[i]) idx = CHAN_W'(i);
    end
    return idx;
  endfunction

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      shadow_q    <= '{default: '0};
      out_chan_q  <= '0;
      out_data_q  <= '0;
      fault_q     <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      shadow_q    <= shadow_d;
      out_chan_q  <= out_chan_d;
      out_data_q  <= out_data_d;
      fault_q     <= fault_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state logic: snapshot in IDLE, walk the pending mask in SEND.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    shadow_d    = shadow_q;
    out_chan_d  = out_chan_q;
    out_data_d  = out_data_q;
    frame_cnt_d = frame_cnt_q;
    // Clear first so a same-cycle set event below overrides it.
    fault_d     = bus.fault_clr ? '0 : fault_q;
    overrun_d   = bus.fault_clr ? 1'b0 : overrun_q;
    sel         = '0;
    remain      = pending_q;
    for (int i = 0; i < int'(NUMADCS); i++) begin
      if (CHAN_W'(i) == out_chan_q) remain[i] = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.data_ready && (bus.chan_en != '0)) begin
          sel        = lowest_set(bus.chan_en);
          shadow_d   = bus.in_data;
          pending_d  = bus.chan_en;
          out_chan_d = sel;
          out_data_d = bus.in_data[sel];
          state_d    = SEND;
          for (int i = 0; i < int'(NUMADCS); i++) begin
            if (bus.chan_en[i] && (bus.in_data[i] > bus.limit)) fault_d[i] = 1'b1;
          end
        end
      end
      SEND: begin
        // Any new frame arriving while a frame is in flight is dropped.
        if (bus.data_ready) overrun_d = 1'b1;
        if (bus.out_ready) begin
          pending_d = remain;
          if (remain == '0) begin
            state_d     = IDLE;
            out_chan_d  = '0;
            out_data_d  = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            sel        = lowest_set(remain);
            out_chan_d = sel;
            out_data_d = shadow_q[sel];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_valid = (state_q == SEND);
  assign bus.busy      = (state_q == SEND);
  assign bus.out_chan  = out_chan_q;
  assign bus.out_data  = out_data_q;
  assign bus.fault     = fault_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_rail_sample_scheduler.sv
// Self-checking bench for rail_sample_scheduler against a queue-based model.
module tb_rail_sample_scheduler;
  localparam int unsigned NCH = 5;
  localparam int unsigned DW  = 16;

  logic sclk = 1'b0;
  logic rst  = 1'b1;

  always #5 sclk = ~sclk;

  rail_sample_scheduler_if #(.NUMADCS(NCH), .DATA_W(DW)) bus ();

  rail_sample_scheduler #(.NUMADCS(NCH), .DATA_W(DW)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [NCH-1:0] exp_fault;
  logic           exp_overrun;
  logic [7:0]     exp_fc;
  logic [DW-1:0]  fd [NCH];
  int             q_ch [$];
  logic [DW-1:0]  q_d [$];

  task automatic model_reset();
    exp_fault   = '0;
    exp_overrun = 1'b0;
    exp_fc      = '0;
    q_ch.delete();
    q_d.delete();
  endtask

  // One frame: snapshot, drain under the chosen ready pattern, check the stream.
  // mode 0: ready always; 1: random ready; 2: stall 4 cycles on channel 2.
  // dr_at: loop cycle at which a second data_ready is injected (-1 = none).
  task automatic do_frame(input logic [NCH-1:0] en, input int mode, input int dr_at,
                          input bit clr_snap);
    int   k;
    int   stall;
    logic rdy;
    bus.data_ready = 1'b1;
    bus.chan_en    = en;
    bus.fault_clr  = clr_snap;
    bus.out_ready  = 1'b1;
    for (int i = 0; i < int'(NCH); i++) bus.in_data[i] = fd[i];
    if (clr_snap) begin
      exp_fault   = '0;
      exp_overrun = 1'b0;
    end
    for (int i = 0; i < int'(NCH); i++) begin
      if (en[i]) begin
        q_ch.push_back(i);
        q_d.push_back(fd[i]);
        if (fd[i] > bus.limit) exp_fault[i] = 1'b1;
      end
    end
    @(negedge sclk);
    bus.data_ready = 1'b0;
    bus.fault_clr  = 1'b0;
    n_checks++;
    if (bus.fault !== exp_fault) begin
      n_fail++;
      $display("FAIL snap_fault: got %b expected %b", bus.fault, exp_fault);
    end
    n_checks++;
    if (bus.busy !== (en != '0)) begin
      n_fail++;
      $display("FAIL snap_busy: got %b expected %b", bus.busy, (en != '0));
    end
    k = 0;
    stall = 0;
    while (q_ch.size() > 0 && k < 200) begin
      n_checks++;
      if (bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL out_valid: cycle %0d got %b expected 1", k, bus.out_valid);
      end
      n_checks++;
      if (bus.out_chan !== 3'(q_ch[0])) begin
        n_fail++;
        $display("FAIL out_chan: cycle %0d got %0d expected %0d", k, bus.out_chan, q_ch[0]);
      end
      n_checks++;
      if (bus.out_data !== q_d[0]) begin
        n_fail++;
        $display("FAIL out_data: cycle %0d got %0d expected %0d", k, bus.out_data, q_d[0]);
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          if (q_ch[0] == 2 && stall < 4) begin
            rdy = 1'b0;
            stall++;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      bus.out_ready = rdy;
      bus.chan_en   = NCH'($urandom);
      if (k == dr_at) begin
        bus.data_ready = 1'b1;
        for (int i = 0; i < int'(NCH); i++) bus.in_data[i] = DW'($urandom);
        exp_overrun = 1'b1;
      end
      @(negedge sclk);
      bus.data_ready = 1'b0;
      if (rdy) begin
        void'(q_ch.pop_front());
        void'(q_d.pop_front());
        if (q_ch.size() == 0) exp_fc = exp_fc + 8'd1;
      end
      k++;
    end
    if (q_ch.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d samples left after %0d cycles", q_ch.size(), k);
      q_ch.delete();
      q_d.delete();
    end
    bus.out_ready = 1'b1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL end_idle: valid %b busy %b expected 0 0", bus.out_valid, bus.busy);
    end
    n_checks++;
    if (bus.out_chan !== '0 || bus.out_data !== '0) begin
      n_fail++;
      $display("FAIL end_zero: chan %0d data %0d expected 0 0", bus.out_chan, bus.out_data);
    end
    n_checks++;
    if (bus.frame_cnt !== exp_fc) begin
      n_fail++;
      $display("FAIL frame_cnt: got %0d expected %0d", bus.frame_cnt, exp_fc);
    end
    n_checks++;
    if (bus.overrun !== exp_overrun) begin
      n_fail++;
      $display("FAIL overrun: got %b expected %b", bus.overrun, exp_overrun);
    end
  endtask

  task automatic set_basic();
    for (int i = 0; i < int'(NCH); i++) fd[i] = DW'((i + 1) * 10);
  endtask

  task automatic test_reset();
    bus.data_ready = 1'b0;
    bus.chan_en    = '0;
    bus.limit      = '1;
    bus.fault_clr  = 1'b0;
    bus.out_ready  = 1'b0;
    for (int i = 0; i < int'(NCH); i++) bus.in_data[i] = '0;
    rst = 1'b1;
    repeat (2) @(negedge sclk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: valid %b busy %b expected 0 0", bus.out_valid, bus.busy);
    end
    n_checks++;
    if (bus.out_chan !== '0 || bus.out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_out: chan %0d data %0d expected 0 0", bus.out_chan, bus.out_data);
    end
    n_checks++;
    if (bus.fault !== '0 || bus.overrun !== 1'b0 || bus.frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_status: fault %b overrun %b cnt %0d expected 0 0 0",
               bus.fault, bus.overrun, bus.frame_cnt);
    end
    rst = 1'b0;
    model_reset();
    @(negedge sclk);
  endtask

  task automatic test_basic();
    bus.limit = '1;
    set_basic();
    do_frame(5'b10101, 0, -1, 1'b0);
    n_checks++;
    if (bus.frame_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL basic_cnt: got %0d expected 1", bus.frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    bus.limit = '1;
    set_basic();
    do_frame(5'b10101, 2, -1, 1'b0);
  endtask

  task automatic test_fault();
    bus.limit = 16'd30;
    set_basic();
    do_frame(5'b10101, 0, -1, 1'b0);
    n_checks++;
    if (bus.fault !== 5'b10000) begin
      n_fail++;
      $display("FAIL fault_limit: got %b expected 10000", bus.fault);
    end
    bus.fault_clr = 1'b1;
    @(negedge sclk);
    bus.fault_clr = 1'b0;
    exp_fault     = '0;
    exp_overrun   = 1'b0;
    n_checks++;
    if (bus.fault !== '0) begin
      n_fail++;
      $display("FAIL fault_clr: got %b expected 00000", bus.fault);
    end
    fd[0] = 16'd100;
    do_frame(5'b00001, 0, -1, 1'b1);
    n_checks++;
    if (bus.fault !== 5'b00001) begin
      n_fail++;
      $display("FAIL fault_set_wins: got %b expected 00001", bus.fault);
    end
  endtask

  task automatic test_overrun();
    bus.limit = '1;
    set_basic();
    do_frame(5'b10101, 0, 1, 1'b0);
    bus.fault_clr = 1'b1;
    @(negedge sclk);
    bus.fault_clr = 1'b0;
    exp_fault     = '0;
    exp_overrun   = 1'b0;
    set_basic();
    do_frame(5'b00001, 0, 0, 1'b0);
    @(negedge sclk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_last: valid %b overrun %b expected 0 1", bus.out_valid, bus.overrun);
    end
  endtask

  task automatic test_zero_en();
    set_basic();
    do_frame(5'b00000, 0, -1, 1'b0);
    repeat (2) begin
      @(negedge sclk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.frame_cnt !== exp_fc) begin
        n_fail++;
        $display("FAIL zero_en: busy %b valid %b cnt %0d expected 0 0 %0d",
                 bus.busy, bus.out_valid, bus.frame_cnt, exp_fc);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bus.limit = '0;
    for (int i = 0; i < int'(NCH); i++) fd[i] = DW'($urandom_range(1, 65535));
    bus.data_ready = 1'b1;
    bus.chan_en    = 5'b11111;
    bus.out_ready  = 1'b1;
    for (int i = 0; i < int'(NCH); i++) bus.in_data[i] = fd[i];
    @(negedge sclk);
    bus.data_ready = 1'b0;
    @(negedge sclk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_chan !== '0 || bus.out_data !== '0) begin
      n_fail++;
      $display("FAIL async_rst_out: valid %b busy %b chan %0d data %0d expected all 0",
               bus.out_valid, bus.busy, bus.out_chan, bus.out_data);
    end
    n_checks++;
    if (bus.fault !== '0 || bus.overrun !== 1'b0 || bus.frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL async_rst_status: fault %b overrun %b cnt %0d expected 0 0 0",
               bus.fault, bus.overrun, bus.frame_cnt);
    end
    @(negedge sclk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge sclk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_after_rst: valid %b expected 0", bus.out_valid);
      end
    end
    bus.limit = '1;
    set_basic();
    do_frame(5'b00110, 0, -1, 1'b0);
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    @(negedge sclk);
    rst = 1'b0;
    model_reset();
    bus.limit = '1;
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < int'(NCH); i++) fd[i] = DW'($urandom);
      do_frame(NCH'(1 << (f % int'(NCH))), 0, -1, 1'b0);
      if (f == 254) begin
        n_checks++;
        if (bus.frame_cnt !== 8'd255) begin
          n_fail++;
          $display("FAIL cnt_255: got %0d expected 255", bus.frame_cnt);
        end
      end
    end
    n_checks++;
    if (bus.frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL cnt_wrap: got %0d expected 0", bus.frame_cnt);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < int'(NCH); i++) fd[i] = DW'($urandom);
      bus.limit = DW'($urandom);
      do_frame(NCH'($urandom), 1, int'($urandom_range(0, 6)) - 1, ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_fault();
    test_overrun();
    test_zero_en();
    test_reset_midframe();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rail_sample_scheduler.md
RAIL_SAMPLE_SCHEDULER -- requirements
Module: rail_sample_scheduler

Interface
REQ-001 The block SHALL have parameter NUMADCS, default 5, giving the number of rail ADC channels.
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the sample width.
REQ-003 Port sclk, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port data_ready, input, 1 bit: one-cycle pulse marking a new decimated frame on in_data.
REQ-006 Port in_data, input, NUMADCS x DATA_W unpacked array: per-channel samples, valid while data_ready is high.
REQ-007 Port chan_en, input, NUMADCS bits: channel enable mask.
REQ-008 Port limit, input, DATA_W bits: unsigned over-limit threshold shared by all channels.
REQ-009 Port fault_clr, input, 1 bit: clears fault and overrun.
REQ-010 Port out_ready, input, 1 bit: downstream accept.
REQ-011 Port out_valid, output, 1 bit: out_chan and out_data are valid.
REQ-012 Port out_chan, output, $clog2(NUMADCS) bits: channel index of the presented sample.
REQ-013 Port out_data, output, DATA_W bits: the presented sample.
REQ-014 Port fault, output, NUMADCS bits: sticky per-channel over-limit flags.
REQ-015 Port overrun, output, 1 bit: sticky dropped-frame flag.
REQ-016 Port frame_cnt, output, 8 bits: count of completed frames.
REQ-017 Port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-018 The FSM SHALL have exactly two states: IDLE and SEND.
REQ-019 In IDLE, when data_ready=1 and chan_en!=0: snapshot all in_data into shadow registers, latch chan_en into the pending mask, and go to SEND.
REQ-020 In IDLE, when data_ready=1 and chan_en==0: stay in IDLE, produce no output, and leave frame_cnt unchanged.
REQ-021 Latency: data_ready sampled at edge N SHALL give out_valid=1 in the cycle following edge N.
REQ-022 In SEND, the presented channel SHALL be the lowest-index set bit of the pending mask (ascending order).
REQ-023 In SEND, out_valid SHALL be 1, and out_chan/out_data SHALL hold stable until the edge where out_valid and out_ready are both 1.
REQ-024 On handshake, clear the presented channel's pending bit; if other bits remain, present the next channel in the following cycle with no bubble.
REQ-025 On handshake of the last pending bit: go to IDLE, drive out_valid=0 in the next cycle, and increment frame_cnt by 1 mod 256 (255 wraps to 0).
REQ-026 chan_en changes during SEND SHALL NOT affect the current frame.
REQ-027 A data_ready pulse while in SEND SHALL drop that frame: shadow registers unchanged, and overrun set.
REQ-028 A data_ready pulse coincident with the last handshake SHALL also be dropped and set overrun; the FSM goes to IDLE.
REQ-029 At snapshot, for each channel i enabled in chan_en with unsigned in_data[i] > limit, set fault[i]; equality SHALL NOT set it.
REQ-030 fault_clr=1 SHALL clear fault and overrun on the next edge; a set event in the same cycle SHALL win.
REQ-031 out_data SHALL be 0 whenever out_valid=0.
REQ-032 out_chan SHALL be 0 whenever out_valid=0.

Reset
REQ-033 rst=1 SHALL asynchronously force: state IDLE, out_valid=0, out_chan=0, out_data=0, fault=0, overrun=0, frame_cnt=0, busy=0, pending mask=0, and shadow registers=0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame; after release, no residual sample is emitted, and the next data_ready starts a fresh frame.

Verification
REQ-035 NUMADCS=5, chan_en=5'b10101, out_ready=1, data_ready with in_data={50,40,30,20,10} (ch4..ch0) -> outputs (0,10),(2,30),(4,50) on 3 consecutive cycles starting 1 cycle after data_ready; frame_cnt=1.
REQ-036 out_ready=0 for 4 cycles during ch2 -> ch2/30 held stable with out_valid=1; resumes with ch4 on the cycle after ready returns.
REQ-037 limit=30, same frame -> fault=5'b10000; then fault_clr -> fault=0; fault_clr coincident with a new over-limit snapshot -> bit remains set.
REQ-038 Second data_ready during SEND -> overrun=1, and the emitted values come from the first frame only; chan_en=0 with data_ready -> no output, busy stays 0.
REQ-039 256 completed frames -> frame_cnt wraps to 0; rst pulse mid-frame -> all outputs 0 immediately, and no stale sample after release.
